sync_fifo: RTL and testbench
============================

// Module: sync_fifo
// PURPOSE
//  Single-clock first-in-first-out buffer with chip-selected write and read ports.
//  Stores DATA_WIDTH-bit words in a 2**ADDR_WIDTH-entry internal dual-port array.
//  Drives full/empty status back to the producer and consumer.
//  Sits between one producer and one consumer in the same clock domain.
// PARAMETERS
//  DATA_WIDTH  8  width of each stored word
//  ADDR_WIDTH  3  pointer width; DEPTH = 2**ADDR_WIDTH (default 8 entries)
// PORTS
//  clk       in   1           single clock, all state updates on rising edge
//  rst       in   1           reset, asynchronous, active-high
//  wr_cs     in   1           write chip select
//  wr_en     in   1           write enable
//  data_in   in   DATA_WIDTH  write data
//  rd_cs     in   1           read chip select
//  rd_en     in   1           read enable
//  data_out  out  DATA_WIDTH  read data, registered
//  empty     out  1           no words stored
//  full      out  1           DEPTH words stored
// BEHAVIOUR
//  - Reset (async assert, sync release): wr_ptr=0, rd_ptr=0, count=0, data_out=0,
//    empty=1, full=0. Array contents are not cleared.
//  - wr_ok = wr_cs & wr_en & !full. On wr_ok: mem[wr_ptr]<=data_in, wr_ptr+1.
//  - rd_ok = rd_cs & rd_en & !empty. On rd_ok: data_out<=mem[rd_ptr], rd_ptr+1.
//  - Read latency: data_out is valid on the edge that accepts the read.
//    It is then visible for the whole following cycle.
//  - data_out holds its last value when no read is accepted.
//  - count is ADDR_WIDTH+1 bits. It increments on wr_ok only and decrements on rd_ok only.
//    It is unchanged when both or neither are accepted.
//  - empty = (count==0). full = (count==DEPTH). Both are decoded combinationally from registered count.
//  - Pointers wrap modulo DEPTH (natural ADDR_WIDTH-bit rollover).
//  - Write while full: ignored, no state change, even if a read is accepted the same cycle.
//  - Read while empty: ignored, data_out unchanged, even if a write is accepted the same cycle.
//    No fall-through.
//  - Simultaneous accepted read and write, when neither full nor empty:
//    - both occur;
//    - count and flags are unchanged;
//    - read returns the old word at rd_ptr.
//  - Reset mid-operation: all pointers, count and data_out return to reset values immediately.
//    Stored data is logically discarded.
//  - Inputs are sampled only on the rising edge. Chip select low makes the matching enable a don't-care.
// CONFIGURATION
//  SYNC_FIFO_ERR_FLAGS_EN
//   defined: adds outputs overflow (1 bit) and underflow (1 bit).
//    - overflow sets on wr_cs&wr_en&full. underflow sets on rd_cs&rd_en&empty.
//    - Both are sticky and cleared only by rst.
//   undefined: ports absent; rejected accesses are silently dropped.
// TESTING (DATA_WIDTH=8, ADDR_WIDTH=3)
//  - Reset: assert rst mid-cycle -> immediately empty=1, full=0, data_out=0.
//  - Fill: write 0x01..0x08 with wr_cs=wr_en=1 ->
//    - full=1 after the 8th edge;
//    - a 9th write of 0xFF is ignored (and sets overflow if SYNC_FIFO_ERR_FLAGS_EN).
//  - Drain: read 8 times ->
//    - data_out sequence 0x01..0x08, one per edge;
//    - empty=1 after the 8th;
//    - a 9th read leaves data_out=0x08.
//  - Gating: wr_en=1, wr_cs=0 with data 0xAA -> no write, empty stays 1.
//    - Likewise rd_en=1, rd_cs=0 -> no read.
//  - Simultaneous: with 4 words held, read+write 0x55 for 10 cycles ->
//    - count stays 4, no flag change;
//    - order preserved across pointer wrap.
//  - Edges: write+read while empty -> write stored, data_out unchanged, empty=0.
//    - Write+read while full -> read returns oldest word, write dropped, full=0 next cycle.

Source files
------------

// File: rtl/sync_fifo.sv
// Single-clock FIFO with chip-selected write/read ports, registered read data and full/empty flags.
// Define SYNC_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_cs,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_cs,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DepthCnt = (ADDR_WIDTH + 1)'(Depth);
    localparam logic [ADDR_WIDTH-1:0] PtrOne = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0] CntOne = (ADDR_WIDTH + 1)'(1);

    logic [DATA_WIDTH-1:0] mem_q [Depth];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  wr_ok, rd_ok;

    assign empty    = (count_q == '0);
    assign full     = (count_q == DepthCnt);
    assign data_out = data_out_q;

    always_comb begin
        wr_ok      = wr_cs & wr_en & ~full;
        rd_ok      = rd_cs & rd_en & ~empty;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (rd_ok) begin
            rd_ptr_d   = rd_ptr_q + PtrOne;
            data_out_d = mem_q[rd_ptr_q];
        end
        // Accepted read and write together leave the occupancy unchanged.
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CntOne;
            2'b01:   count_d = count_q - CntOne;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
        end
    end

    // Storage is not reset; pointers alone define which words are live.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    always_comb begin
        overflow_d  = overflow_q | (wr_cs & wr_en & full);
        underflow_d = underflow_q | (rd_cs & rd_en & empty);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: directed scenarios plus random traffic against a queue model.
module tb_sync_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_cs = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       rd_cs = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] data_out;
    logic       empty;
    logic       full;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic       overflow;
    logic       underflow;
`endif

    int checks = 0;
    int failures = 0;

    logic [7:0] model_q[$];
    logic [7:0] model_dout = 8'h00;
    logic       model_ovf = 1'b0;
    logic       model_udf = 1'b0;

    sync_fifo #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_cs    (wr_cs),
        .wr_en    (wr_en),
        .data_in  (data_in),
        .rd_cs    (rd_cs),
        .rd_en    (rd_en),
        .data_out (data_out),
        .empty    (empty),
        .full     (full)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        ,
        .overflow (overflow),
        .underflow(underflow)
`endif
    );

    always #5 clk = ~clk;

    // Apply one cycle of stimulus, advance the model, leave inputs idle 1ns after the edge.
    task automatic drive_cycle(input logic wcs, input logic wen, input logic [7:0] din,
                               input logic rcs, input logic ren);
        bit was_full, was_empty;
        wr_cs = wcs; wr_en = wen; data_in = din; rd_cs = rcs; rd_en = ren;
        @(posedge clk);
        was_full  = (model_q.size() == 8);
        was_empty = (model_q.size() == 0);
        if (wcs && wen && was_full) model_ovf = 1'b1;
        if (rcs && ren && was_empty) model_udf = 1'b1;
        if (rcs && ren && !was_empty) model_dout = model_q.pop_front();
        if (wcs && wen && !was_full) model_q.push_back(din);
        #1;
        wr_cs = 1'b0; wr_en = 1'b0; rd_cs = 1'b0; rd_en = 1'b0; data_in = 8'h00;
    endtask

    task automatic model_reset();
        model_q.delete();
        model_dout = 8'h00;
        model_ovf  = 1'b0;
        model_udf  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b want=1", empty); end
        checks++;
        if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b want=0", full); end
        checks++;
        if (data_out !== 8'h00) begin
            failures++; $display("FAIL reset_data_out got=%h want=00", data_out);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) begin
            drive_cycle(1'b1, 1'b1, 8'(i), 1'b0, 1'b0);
            checks++;
            if (full !== (i == 8)) begin
                failures++; $display("FAIL fill_full[%0d] got=%b want=%b", i, full, (i == 8));
            end
            checks++;
            if (empty !== 1'b0) begin
                failures++; $display("FAIL fill_empty[%0d] got=%b want=0", i, empty);
            end
        end
        drive_cycle(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
        checks++;
        if (full !== 1'b1) begin failures++; $display("FAIL fill_9th_full got=%b want=1", full); end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        checks++;
        if (overflow !== 1'b1) begin
            failures++; $display("FAIL fill_overflow got=%b want=1", overflow);
        end
`endif
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 8; i++) begin
            drive_cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
            checks++;
            if (data_out !== 8'(i)) begin
                failures++; $display("FAIL drain_data[%0d] got=%h want=%h", i, data_out, 8'(i));
            end
            checks++;
            if (empty !== (i == 8)) begin
                failures++; $display("FAIL drain_empty[%0d] got=%b want=%b", i, empty, (i == 8));
            end
        end
        drive_cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        checks++;
        if (data_out !== 8'h08) begin
            failures++; $display("FAIL drain_9th_data got=%h want=08", data_out);
        end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        checks++;
        if (underflow !== 1'b1) begin
            failures++; $display("FAIL drain_underflow got=%b want=1", underflow);
        end
`endif
    endtask

    task automatic test_gating();
        drive_cycle(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0);
        checks++;
        if (empty !== 1'b1) begin failures++; $display("FAIL gate_wr_empty got=%b want=1", empty); end
        drive_cycle(1'b1, 1'b1, 8'h33, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        checks++;
        if (data_out !== 8'h08) begin
            failures++; $display("FAIL gate_rd_data got=%h want=08", data_out);
        end
        checks++;
        if (empty !== 1'b0) begin failures++; $display("FAIL gate_rd_empty got=%b want=0", empty); end
        drive_cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        checks++;
        if (data_out !== 8'h33) begin
            failures++; $display("FAIL gate_read_back got=%h want=33", data_out);
        end
    endtask

    task automatic test_simultaneous();
        logic [7:0] seeds[4];
        for (int i = 0; i < 4; i++) begin
            seeds[i] = 8'($urandom_range(0, 255));
            drive_cycle(1'b1, 1'b1, seeds[i], 1'b0, 1'b0);
        end
        for (int c = 0; c < 10; c++) begin
            drive_cycle(1'b1, 1'b1, 8'h55, 1'b1, 1'b1);
            checks++;
            if (data_out !== ((c < 4) ? seeds[c] : 8'h55)) begin
                failures++;
                $display("FAIL simul_data[%0d] got=%h want=%h", c, data_out,
                         ((c < 4) ? seeds[c] : 8'h55));
            end
            checks++;
            if ({empty, full} !== 2'b00) begin
                failures++; $display("FAIL simul_flags[%0d] got=%b want=00", c, {empty, full});
            end
        end
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
            checks++;
            if (data_out !== 8'h55 || empty !== (i == 3)) begin
                failures++;
                $display("FAIL simul_drain[%0d] got=%h/%b want=55/%b", i, data_out, empty, (i == 3));
            end
        end
    endtask

    task automatic test_edges();
        drive_cycle(1'b1, 1'b1, 8'h77, 1'b1, 1'b1);
        checks++;
        if (data_out !== 8'h55 || empty !== 1'b0) begin
            failures++;
            $display("FAIL edge_empty_rw got=%h/%b want=55/0", data_out, empty);
        end
        for (int i = 1; i < 8; i++) drive_cycle(1'b1, 1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
        checks++;
        if (full !== 1'b1) begin failures++; $display("FAIL edge_filled got=%b want=1", full); end
        drive_cycle(1'b1, 1'b1, 8'hEE, 1'b1, 1'b1);
        checks++;
        if (data_out !== 8'h77 || full !== 1'b0) begin
            failures++;
            $display("FAIL edge_full_rw got=%h/%b want=77/0", data_out, full);
        end
        for (int i = 1; i < 8; i++) begin
            drive_cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
            checks++;
            if (data_out !== 8'(8'h70 + i)) begin
                failures++;
                $display("FAIL edge_drain[%0d] got=%h want=%h", i, data_out, 8'(8'h70 + i));
            end
        end
        checks++;
        if (empty !== 1'b1) begin failures++; $display("FAIL edge_final_empty got=%b want=1", empty); end
    endtask

    task automatic test_random();
        int errs = 0;
        for (int c = 0; c < 400; c++) begin
            drive_cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                        8'($urandom_range(0, 255)),
                        1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
            checks++;
            if (data_out !== model_dout || empty !== (model_q.size() == 0) ||
                full !== (model_q.size() == 8)) begin
                failures++;
                if (errs++ < 10) begin
                    $display("FAIL random[%0d] got=%h/%b/%b want=%h/%b/%b", c, data_out, empty,
                             full, model_dout, (model_q.size() == 0), (model_q.size() == 8));
                end
            end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
            checks++;
            if (overflow !== model_ovf || underflow !== model_udf) begin
                failures++;
                $display("FAIL random_err[%0d] got=%b%b want=%b%b", c, overflow, underflow,
                         model_ovf, model_udf);
            end
`endif
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({empty, full} !== 2'b10 || data_out !== 8'h00) begin
            failures++;
            $display("FAIL reset_mid got=%b%b/%h want=10/00", empty, full, data_out);
        end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        checks++;
        if ({overflow, underflow} !== 2'b00) begin
            failures++; $display("FAIL reset_mid_err got=%b%b want=00", overflow, underflow);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        drive_cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        checks++;
        if (data_out !== 8'h00) begin
            failures++; $display("FAIL reset_mid_rd_empty got=%h want=00", data_out);
        end
        drive_cycle(1'b1, 1'b1, 8'h9D, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        checks++;
        if (data_out !== 8'h9D || empty !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_reuse got=%h/%b want=9d/1", data_out, empty);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_gating();
        test_simultaneous();
        test_edges();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
